// File: rtl/nb_mult_pkg.sv
// rtl/nb_mult_pkg.sv - shared types and elaboration-time helpers for the type-II ONB multiplier
package nb_mult_pkg;

    localparam int MMAX = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COMP = 2'd1,
        DONE = 2'd2
    } nb_state_e;

    function automatic int cdiv(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Type-II ONB exists iff p = 2m+1 is prime and 2 has order 2m, or order m with p = 3 mod 4.
    function automatic logic onb2_legal(input int m);
        int   p;
        int   ord;
        int   x;
        logic prime;
        if (m < 2 || m > MMAX) return 1'b0;
        p     = 2 * m + 1;
        prime = 1'b1;
        for (int q = 2; q * q <= p; q++) begin
            if (p % q == 0) prime = 1'b0;
        end
        if (!prime) return 1'b0;
        ord = 1;
        x   = 2;
        while (x != 1) begin
            x   = (x * 2) % p;
            ord = ord + 1;
        end
        return (ord == 2 * m) || ((p % 4 == 3) && (ord == m));
    endfunction

    function automatic logic [MMAX*MMAX-1:0] lambda_mat(input int m);
        logic [MMAX*MMAX-1:0] lam;
        int                   p;
        int                   s;
        int                   df;
        int                   pw [MMAX];
        lam   = '0;
        p     = 2 * m + 1;
        pw[0] = 1;
        for (int i = 1; i < MMAX; i++) pw[i] = (pw[i-1] * 2) % p;
        for (int i = 0; i < m; i++) begin
            for (int j = 0; j < m; j++) begin
                s  = (pw[i] + pw[j]) % p;
                df = (pw[i] - pw[j] + p) % p;
                if (s == 1 || s == p - 1 || df == 1 || df == p - 1) lam[i*MMAX+j] = 1'b1;
            end
        end
        return lam;
    endfunction

endpackage

// File: rtl/nb_mult_f.sv
// rtl/nb_mult_f.sv - combinational Massey-Omura product bit z = sum(lambda_ij a_i b_j)
module nb_mult_f
    import nb_mult_pkg::*;
#(
    parameter int M = 5
) (
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic         z
);

    localparam logic [MMAX*MMAX-1:0] LAM = lambda_mat(M);

    always_comb begin
        z = 1'b0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < M; j++) begin
                if (LAM[i*MMAX+j]) z = z ^ (a[i] & b[j]);
            end
        end
    end

endmodule

// File: rtl/nb_mult_digit.sv
// rtl/nb_mult_digit.sv - digit-serial GF(2^M) ONB multiplier; NB_MULT_SQUARE_EN adds one-cycle squaring
module nb_mult_digit
    import nb_mult_pkg::*;
#(
    parameter int M = 5,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         start,
    input  logic [M-1:0] A,
    input  logic [M-1:0] B,
`ifdef NB_MULT_SQUARE_EN
    input  logic         sq,
`endif
    output logic         busy,
    output logic         done,
    output logic [M-1:0] Z
);

    localparam int KW = $clog2(M + 1);

    if (!onb2_legal(M) || D < 1 || D > M) begin : g_param_check
        $error("nb_mult_digit: no type-II ONB for this M, or D out of range");
    end

    nb_state_e    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [M-1:0] ra_q, ra_d, rb_q, rb_d;
    logic [M-1:0] acc_q, acc_d;
    logic [M-1:0] z_q, z_d;

    logic [D-1:0] zd;
    logic [M-1:0] zd_ext;
    logic [M-1:0] acc_next;
    logic [M-1:0] ra_rot, rb_rot;
    logic         last_step;

    // Copy d sees the operands advanced by d more positions than the current digit base k.
    for (genvar d = 0; d < D; d++) begin : g_dig
        logic [M-1:0] a_rot, b_rot;
        for (genvar i = 0; i < M; i++) begin : g_bit
            assign a_rot[i] = ra_q[(i + d) % M];
            assign b_rot[i] = rb_q[(i + d) % M];
        end
        nb_mult_f #(.M(M)) u_f (
            .a (a_rot),
            .b (b_rot),
            .z (zd[d])
        );
    end

    for (genvar i = 0; i < M; i++) begin : g_rot
        assign ra_rot[i] = ra_q[(i + D) % M];
        assign rb_rot[i] = rb_q[(i + D) % M];
    end

    // Digit bits past index M-1 fall off the shift, so a short final digit never wraps.
    always_comb begin
        zd_ext         = '0;
        zd_ext[D-1:0]  = zd;
        acc_next       = acc_q | (zd_ext << k_q);
    end

    assign last_step = (int'(k_q) + D >= M);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        acc_d   = acc_q;
        z_d     = z_q;
        if (en) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
`ifdef NB_MULT_SQUARE_EN
                        if (sq) begin
                            z_d     = {A[M-2:0], A[M-1]};
                            state_d = DONE;
                        end else
`endif
                        begin
                            ra_d    = A;
                            rb_d    = B;
                            k_d     = '0;
                            acc_d   = '0;
                            state_d = COMP;
                        end
                    end
                end
                COMP: begin
                    ra_d = ra_rot;
                    rb_d = rb_rot;
                    if (last_step) begin
                        z_d     = acc_next;
                        k_d     = '0;
                        state_d = DONE;
                    end else begin
                        acc_d = acc_next;
                        k_d   = k_q + KW'(D);
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            acc_q   <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            acc_q   <= acc_d;
            z_q     <= z_d;
        end
    end

    assign busy = (state_q == COMP);
    assign done = (state_q == DONE);
    assign Z    = z_q;

endmodule

// File: tb/tb_nb_mult_digit.sv
// tb/tb_nb_mult_digit.sv - scoreboard bench for nb_mult_digit at (M,D) = (5,1), (5,5), (6,4)
module tb_nb_mult_digit;

    localparam int NI = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic [5:0] av    = '0;
    logic [5:0] bv    = '0;
    logic       st      [NI] = '{1'b0, 1'b0, 1'b0};
    logic       busy_w  [NI];
    logic       done_w  [NI];
    logic [4:0] z0;
    logic [4:0] z1;
    logic [5:0] z2;

    int         checks = 0;
    int         errors = 0;
    int         ecnt   = 0;
    int         t0      [NI] = '{-100, -100, -100};
    int         free_at [NI] = '{0, 0, 0};
    logic [5:0] q0 [$];
    logic [5:0] q1 [$];
    logic [5:0] q2 [$];
    logic [5:0] zheld     [NI] = '{6'd0, 6'd0, 6'd0};
    logic       prev_done [NI] = '{1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    nb_mult_digit #(.M(5), .D(1)) u_m5d1 (
        .clk(clk), .rst_n(rst_n), .en(en), .start(st[0]), .A(av[4:0]), .B(bv[4:0]),
        .busy(busy_w[0]), .done(done_w[0]), .Z(z0)
    );
    nb_mult_digit #(.M(5), .D(5)) u_m5d5 (
        .clk(clk), .rst_n(rst_n), .en(en), .start(st[1]), .A(av[4:0]), .B(bv[4:0]),
        .busy(busy_w[1]), .done(done_w[1]), .Z(z1)
    );
    nb_mult_digit #(.M(6), .D(4)) u_m6d4 (
        .clk(clk), .rst_n(rst_n), .en(en), .start(st[2]), .A(av), .B(bv),
        .busy(busy_w[2]), .done(done_w[2]), .Z(z2)
    );

    function automatic int m_of(input int i);
        return (i == 2) ? 6 : 5;
    endfunction

    function automatic int d_of(input int i);
        case (i)
            0:       return 1;
            1:       return 5;
            default: return 4;
        endcase
    endfunction

    function automatic int n_of(input int i);
        return (m_of(i) + d_of(i) - 1) / d_of(i);
    endfunction

    function automatic logic [5:0] z_of(input int i);
        case (i)
            0:       return {1'b0, z0};
            1:       return {1'b0, z1};
            default: return z2;
        endcase
    endfunction

    // z_k = sum over i,j of lambda_ij a_(i+k) b_(j+k), lambda_ij = [2^i +- 2^j = +-1 mod 2m+1]
    function automatic logic [5:0] ref_mul(input int m, input logic [5:0] a, input logic [5:0] b);
        int         p;
        int         s;
        int         df;
        int         pw [6];
        logic [5:0] z;
        p     = 2 * m + 1;
        pw[0] = 1;
        for (int i = 1; i < 6; i++) pw[i] = (pw[i-1] * 2) % p;
        z = '0;
        for (int k = 0; k < m; k++) begin
            for (int i = 0; i < m; i++) begin
                for (int j = 0; j < m; j++) begin
                    s  = (pw[i] + pw[j]) % p;
                    df = (pw[i] - pw[j] + p) % p;
                    if ((s == 1 || s == p - 1 || df == 1 || df == p - 1) &&
                        a[(i + k) % m] && b[(j + k) % m])
                        z[k] = ~z[k];
                end
            end
        end
        return z;
    endfunction

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic check(input string name, input int i, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %b want %b at %0t", name, i, act, exp, $time);
        end
    endtask

    // Reference handshake: a start is taken on an enabled edge once N+2 enabled edges have passed.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ecnt = 0;
            for (int i = 0; i < NI; i++) begin
                t0[i]      = -100;
                free_at[i] = 0;
            end
            q0.delete();
            q1.delete();
            q2.delete();
        end else if (en) begin
            ecnt = ecnt + 1;
            for (int i = 0; i < NI; i++) begin
                if (st[i] && ecnt >= free_at[i]) begin
                    t0[i]      = ecnt;
                    free_at[i] = ecnt + n_of(i) + 2;
                    case (i)
                        0:       q0.push_back(ref_mul(5, av, bv));
                        1:       q1.push_back(ref_mul(5, av, bv));
                        default: q2.push_back(ref_mul(6, av, bv));
                    endcase
                end
            end
        end
    end

    always @(negedge clk) begin : mon
        logic eb;
        logic ed;
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                prev_done[i] = 1'b0;
                zheld[i]     = '0;
            end else begin
                eb = (ecnt >= t0[i]) && (ecnt < t0[i] + n_of(i));
                ed = (ecnt == t0[i] + n_of(i));
                check("busy", i, 6'(busy_w[i]), 6'(eb));
                check("done", i, 6'(done_w[i]), 6'(ed));
                if (done_w[i] && !prev_done[i]) begin
                    if (qsize(i) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_done[%0d] got done=1 want no pending result at %0t", i, $time);
                    end else begin
                        case (i)
                            0:       zheld[i] = q0.pop_front();
                            1:       zheld[i] = q1.pop_front();
                            default: zheld[i] = q2.pop_front();
                        endcase
                        check("z_result", i, z_of(i), zheld[i]);
                    end
                end else begin
                    check("z_hold", i, z_of(i), zheld[i]);
                end
                prev_done[i] = done_w[i];
            end
        end
    end

    task automatic wait_idle();
        int  n;
        logic idle;
        n    = 0;
        idle = 1'b0;
        while (!idle && n < 300) begin
            idle = 1'b1;
            for (int i = 0; i < NI; i++) if (free_at[i] > ecnt + 1) idle = 1'b0;
            if (!idle) begin
                @(posedge clk);
                #3;
                n++;
            end
        end
        if (!idle) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout got busy after %0d cycles want idle", n);
        end
    endtask

    task automatic run_one(input logic [5:0] a, input logic [5:0] b);
        wait_idle();
        av = a;
        bv = b;
        for (int i = 0; i < NI; i++) st[i] = 1'b1;
        @(posedge clk);
        #3;
        for (int i = 0; i < NI; i++) st[i] = 1'b0;
        wait_idle();
    endtask

    initial begin
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check("rst_busy", i, 6'(busy_w[i]), 6'd0);
            check("rst_done", i, 6'(done_w[i]), 6'd0);
            check("rst_z", i, z_of(i), 6'd0);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        en    = 1'b1;

        // All-ones is the unit in both fields (5 and 6 bits).
        run_one(6'b011001, 6'b111111);
        for (int i = 0; i < NI; i++) check("unit", i, z_of(i), 6'b011001);
        run_one(6'b000000, 6'b010110);
        for (int i = 0; i < NI; i++) check("zero", i, z_of(i), 6'b000000);
        run_one(6'b010111, 6'b000011);
        run_one(6'b000011, 6'b010111);

        // Stall with en low mid-multiply.
        av = 6'b101101;
        bv = 6'b110011;
        for (int i = 0; i < NI; i++) st[i] = 1'b1;
        @(posedge clk);
        #3;
        for (int i = 0; i < NI; i++) st[i] = 1'b0;
        @(posedge clk);
        #3;
        en = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #3;
        end
        en = 1'b1;
        wait_idle();

        // Reset in the middle of the D=1 multiply.
        av = 6'b010111;
        bv = 6'b000011;
        for (int i = 0; i < NI; i++) st[i] = 1'b1;
        @(posedge clk);
        #3;
        for (int i = 0; i < NI; i++) st[i] = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #3;
        end
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check("async_rst_busy", i, 6'(busy_w[i]), 6'd0);
            check("async_rst_done", i, 6'(done_w[i]), 6'd0);
            check("async_rst_z", i, z_of(i), 6'd0);
        end
        @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        run_one(6'b010111, 6'b000011);

        // Random operands, starts held or toggled, random clock-enable gaps.
        for (int c = 0; c < 1500; c++) begin
            en = ($urandom_range(0, 4) != 0);
            for (int i = 0; i < NI; i++) st[i] = ($urandom_range(0, 3) != 0);
            av = 6'($urandom);
            bv = 6'($urandom);
            if ($urandom_range(0, 15) == 0) av = '0;
            if ($urandom_range(0, 15) == 0) bv = '1;
            @(posedge clk);
            #3;
        end
        for (int i = 0; i < NI; i++) st[i] = 1'b0;
        en = 1'b1;
        wait_idle();
        @(negedge clk);
        #1;
        for (int i = 0; i < NI; i++) check("pending", i, 6'(qsize(i)), 6'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nb_mult_digit.md
# nb_mult_digit

Parametrised digit-serial Massey-Omura multiplier over GF(2^M) in a type-II optimal normal basis (ONB). It is the successor to the fixed 5-bit bit-serial normal-basis multiplier and generalises it in field degree M and digit size D. It adds a start/busy/done handshake, an asynchronous reset and an optional one-cycle squaring mode. It sits in the finite-field datapath as the core multiply primitive.

## Interface
Parameters:
- M, default 5: field degree. Legal only where a type-II ONB exists (2M+1 prime, plus the ONB condition), e.g. 2, 3, 5, 6, 9, 11, 14, 18, 23, 26, 29. Any other value is an elaboration error.
- D, default 1: output bits produced per cycle, 1..M.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: clock enable. When low, every register holds.
- start, input, 1: request a multiply. Sampled only when idle and en=1.
- A, input, M: operand A. Bit i is the coefficient of β^(2^i).
- B, input, M: operand B. Same encoding as A.
- sq, input, 1: squaring request. Present only with NB_MULT_SQUARE_EN.
- busy, output, 1: a multiply is in progress.
- done, output, 1: one-cycle pulse; Z is valid in this cycle.
- Z, output, M: the product A·B. Held until the next completion.

## Operation
- States:
  - IDLE → LOAD when start=1 (with en=1).
  - LOAD → COMP.
  - COMP → DONE after N=ceil(M/D) digit steps.
  - DONE → IDLE.
  - In practice LOAD folds into the start edge, leaving IDLE/COMP/DONE.
- Start edge: capture A and B into rotate registers ra and rb, clear digit counter k.
- Product rule: z_k = Σ λ_ij·a_(i+k)·b_(j+k), with indices taken mod M.
- λ_ij = 1 iff 2^i ± 2^j ≡ ±1 (mod 2M+1). This is the type-II ONB rule, evaluated at elaboration.
- Each COMP edge:
  - Compute D bits z_k..z_(k+D-1) using D copies of f.
  - Copy d sees ra and rb rotated so that bit i holds a_(i+k+d) and b_(i+k+d).
  - Then rotate ra and rb by D and advance k by D.
- Final step when D does not divide M: any bits with index ≥ M are discarded. No wrap-around writes are allowed.
- Z is driven only from the output register, which is loaded on the final COMP edge. Partial results never appear on Z.
- start while busy=1 or done=1 is ignored, with no queueing.
- Operands are captured at the start edge. A and B may change freely afterwards.
- A=0 or B=0 gives Z=0. All-ones is the field unit, so A·1 = A.

## Timing
- Reset values:
  - busy=0, done=0, Z=0.
  - State IDLE, k=0, ra=rb=0.
  - Reset acts immediately, including mid-operation; the in-flight result is lost.
- Start sampled at edge t0 → busy=1 after t0. The digit steps occur on edges t0+1..t0+N.
- After edge t0+N: done=1, busy=0, Z=result.
- After edge t0+N+1: done=0 and the block is IDLE; it accepts a new start at this edge or later.
- Latency from the start edge to done is N+1 enabled cycles. At M=5, D=1 that is 6 cycles.
- en=0 stretches every phase, and done is held high until the next enabled edge.
- Throughput is one result per N+2 enabled cycles.

## Configuration
- Macro: NB_MULT_SQUARE_EN.
- Defined:
  - The sq port exists.
  - start with sq=1 ignores B and loads Z with A rotated left by 1 (z_i = a_(i-1)) on the next enabled edge. That is A².
  - done pulses after that edge, and busy never asserts.
  - start with sq=0 gives a normal multiply.
- Undefined: the sq port and its logic are absent, and every start is a full multiply.

## Structure
- Package nb_mult_pkg:
  - Function cdiv(a,b).
  - Function onb2_legal(M), used by an elaboration-time assertion.
  - Function lambda_mat(M), returning an M×M bit matrix.
  - State enum {IDLE, COMP, DONE}.
- Sub-module nb_mult_f:
  - Purely combinational, parameter M.
  - Inputs a[M] and b[M], output z = Σ λ_ij a_i b_j.
  - Instantiated D times in a generate loop.
- Top level holds the FSM, counter, rotate registers, output register and square path.

## Test plan
- Reset mid-COMP (M=5, D=1, start A=10111, B=00011, assert rst_n=0 at cycle 3) → busy=0, done=0, Z=00000 immediately. A fresh start afterwards completes normally.
- M=5, D=1: A=11001, B=11111 → Z=11001, with done exactly 6 cycles after the start edge. A=00000, B=10110 → Z=00000.
- M=5, D=5: A=10111, B=00011 compared against A=00011, B=10111 → identical Z, with latency 2 cycles. Repeat at D=1; Z must match the D=5 result.
- M=6, D=4 (partial final digit), 200 random operand pairs → Z matches the bench's behavioural λ-model, and no bits beyond index 5 change.
- Handshake: start held high continuously and toggled while busy, plus en=0 for 3 cycles mid-COMP → extra starts ignored, one done per accepted start, done held while en=0.
- With NB_MULT_SQUARE_EN: sq=1, A=00011 → Z=00110 with done 1 cycle after start and busy never high. Cross-check against a full multiply with A=B=00011.
